tile_line_fetcher: RTL and testbench

- Upstream feeder of the 4-pixel line renderer.
- On each scanline start it walks the tilemap row for that line and reads each tile's entry and its two 16-bit pattern words from VRAM.
- It applies scroll and flip, then issues one render_start per pattern word with the line-buffer index and data.
- Sits between the VRAM arbiter and the renderer; driven by the video timing generator.

---
 rtl/tile_line_fetcher_pkg.sv | 21 ++
 rtl/tile_line_fetcher_if.sv | 25 ++
 rtl/tile_line_fetcher.sv | 187 ++++++++++++++++++
 tb/tb_tile_line_fetcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_line_fetcher_pkg.sv
// Shared video definitions for the tile line fetcher: tilemap entry layout,
// map/pattern geometry and the fetch FSM state encoding.
package tile_line_fetcher_pkg;

  localparam int TILE_IDX_MSB = 8;
  localparam int HFLIP_BIT    = 9;
  localparam int VFLIP_BIT    = 10;
  localparam int TILEMAP_COLS = 64;
  localparam int TILE_WORDS   = 16;
  localparam int LINE_BUF_W   = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAP  = 3'd1,
    ST_PAT0 = 3'd2,
    ST_PAT1 = 3'd3,
    ST_ISS0 = 3'd4,
    ST_ISS1 = 3'd5
  } state_e;

endpackage

// File: rtl/tile_line_fetcher_if.sv
// VRAM read port and renderer start port of the tile line fetcher, bundled.
// master = fetcher side, slave = VRAM arbiter / renderer side.
interface tile_line_fetcher_if #(
  parameter int VADDR_W = 13
) ();
  logic               vram_req;
  logic [VADDR_W-1:0] vram_addr;
  logic               vram_ack;
  logic [15:0]        vram_rddata;
  logic [8:0]         render_idx;
  logic [15:0]        render_data;
  logic               render_start;
  logic               render_busy;
  logic               render_last_pixel;

  modport master (
    output vram_req, vram_addr, render_idx, render_data, render_start,
    input  vram_ack, vram_rddata, render_busy, render_last_pixel
  );

  modport slave (
    input  vram_req, vram_addr, render_idx, render_data, render_start,
    output vram_ack, vram_rddata, render_busy, render_last_pixel
  );
endinterface

// File: rtl/tile_line_fetcher.sv
// Walks one tilemap row per scanline, fetches entry + two pattern words per
// tile from VRAM, applies scroll/flip and hands each word to the line renderer.
module tile_line_fetcher
  import tile_line_fetcher_pkg::*;
#(
  parameter int NUM_TILES = 41,
  parameter int VADDR_W   = 13
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               line_start,
  input  logic [7:0]         line_num,
  input  logic [8:0]         scroll_x,
  input  logic [7:0]         scroll_y,
  input  logic [VADDR_W-1:0] map_base,
  tile_line_fetcher_if.master bus,
  output logic               line_done,
  output logic               busy
);

  function automatic logic [VADDR_W-1:0] map_addr(input logic [VADDR_W-1:0] base,
                                                  input logic [4:0] row,
                                                  input logic [5:0] col0,
                                                  input logic [5:0] t);
    logic [5:0] col;
    col = col0 + t;
    return VADDR_W'(32'(base) + 32'(row) * 32'(TILEMAP_COLS) + 32'(col));
  endfunction

  function automatic logic [VADDR_W-1:0] pat_addr(input logic [10:0] entry,
                                                  input logic [2:0] ypix,
                                                  input logic w);
    logic [2:0] prow;
    prow = entry[VFLIP_BIT] ? (3'd7 - ypix) : ypix;
    return VADDR_W'(32'(entry[TILE_IDX_MSB:0]) * 32'(TILE_WORDS) + 32'(prow) * 32'd2 + 32'(w));
  endfunction

  function automatic logic [15:0] nib_rev(input logic [15:0] d);
    return {d[3:0], d[7:4], d[11:8], d[15:12]};
  endfunction

  // Negative offsets wrap into the unused top of the line buffer.
  function automatic logic [LINE_BUF_W-1:0] line_idx(input logic [5:0] t,
                                                     input logic k,
                                                     input logic [2:0] fine);
    return LINE_BUF_W'(32'(t) * 32'd8 + 32'(k) * 32'd4 - 32'(fine));
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [2:0]         ypix_q, ypix_d;
  logic [5:0]         col0_q, col0_d;
  logic [2:0]         fine_q, fine_d;
  logic [VADDR_W-1:0] base_q, base_d;
  logic [5:0]         t_q, t_d;
  logic [10:0]        entry_q, entry_d;
  logic [15:0]        w0_q, w0_d, w1_q, w1_d;
  logic               drain_q, drain_d;
  logic               req_q, req_d;
  logic [VADDR_W-1:0] addr_q, addr_d;
  logic [8:0]         idx_q, idx_d;
  logic [15:0]        data_q, data_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [7:0]         y_s;
  logic               ready_s, final_s, finishing_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q; row_d = row_q; ypix_d = ypix_q; col0_d = col0_q;
    fine_d = fine_q; base_d = base_q; t_d = t_q; entry_d = entry_q;
    w0_d = w0_q; w1_d = w1_q; drain_d = drain_q; req_d = req_q; addr_d = addr_q;
    idx_d = idx_q; data_d = data_q; start_d = 1'b0; done_d = 1'b0;
    y_s         = line_num + scroll_y;
    ready_s     = !bus.render_busy || bus.render_last_pixel;
    final_s     = (t_q == 6'(NUM_TILES - 1));
    finishing_s = (state_q == ST_ISS1) && ready_s && final_s;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_MAP, ST_PAT0, ST_PAT1: begin
        if (!req_q) begin
          req_d = 1'b1;
          if (state_q == ST_MAP)       addr_d = map_addr(base_q, row_q, col0_q, t_q);
          else if (state_q == ST_PAT0) addr_d = pat_addr(entry_q, ypix_q, 1'b0);
          else                         addr_d = pat_addr(entry_q, ypix_q, 1'b1);
        end else if (bus.vram_ack) begin
          req_d = 1'b0;
          if (drain_q) begin
            // Completed read belonged to an aborted line; discard it.
            drain_d = 1'b0;
          end else if (state_q == ST_MAP) begin
            entry_d = bus.vram_rddata[10:0];
            state_d = ST_PAT0;
          end else if (state_q == ST_PAT0) begin
            w0_d    = bus.vram_rddata;
            state_d = ST_PAT1;
          end else begin
            w1_d    = bus.vram_rddata;
            state_d = ST_ISS0;
          end
        end else begin
          req_d = req_q;
        end
      end
      ST_ISS0: begin
        if (ready_s) begin
          start_d = 1'b1;
          idx_d   = line_idx(t_q, 1'b0, fine_q);
          data_d  = entry_q[HFLIP_BIT] ? nib_rev(w1_q) : w0_q;
          state_d = ST_ISS1;
        end else begin
          state_d = ST_ISS0;
        end
      end
      ST_ISS1: begin
        if (ready_s) begin
          start_d = 1'b1;
          idx_d   = line_idx(t_q, 1'b1, fine_q);
          data_d  = entry_q[HFLIP_BIT] ? nib_rev(w0_q) : w1_q;
          if (final_s) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            t_d     = t_q + 6'd1;
            state_d = ST_MAP;
          end
        end else begin
          state_d = ST_ISS1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (line_start) begin
      row_d   = y_s[7:3];
      ypix_d  = y_s[2:0];
      col0_d  = scroll_x[8:3];
      fine_d  = scroll_x[2:0];
      base_d  = map_base;
      t_d     = 6'd0;
      state_d = ST_MAP;
      if (state_q == ST_IDLE || finishing_s) begin
        req_d   = 1'b0;
        drain_d = 1'b0;
      end else begin
        // Abort: an unacked read stays on the bus until its ack arrives.
        start_d = 1'b0;
        done_d  = 1'b0;
        idx_d   = idx_q;
        data_d  = data_q;
        req_d   = req_q && !bus.vram_ack;
        drain_d = req_q && !bus.vram_ack;
      end
    end else begin
      base_d = base_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE; row_q <= 5'd0; ypix_q <= 3'd0; col0_q <= 6'd0;
      fine_q <= 3'd0; base_q <= '0; t_q <= 6'd0; entry_q <= 11'd0;
      w0_q <= 16'd0; w1_q <= 16'd0; drain_q <= 1'b0; req_q <= 1'b0;
      addr_q <= '0; idx_q <= 9'd0; data_q <= 16'd0; start_q <= 1'b0;
      done_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d; row_q <= row_d; ypix_q <= ypix_d; col0_q <= col0_d;
      fine_q <= fine_d; base_q <= base_d; t_q <= t_d; entry_q <= entry_d;
      w0_q <= w0_d; w1_q <= w1_d; drain_q <= drain_d; req_q <= req_d;
      addr_q <= addr_d; idx_q <= idx_d; data_q <= data_d; start_q <= start_d;
      done_q <= done_d; busy_q <= busy_d;
    end
  end

  assign bus.vram_req     = req_q;
  assign bus.vram_addr    = addr_q;
  assign bus.render_idx   = idx_q;
  assign bus.render_data  = data_q;
  assign bus.render_start = start_q;
  assign line_done        = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher: VRAM responder with programmable
// latency, render_start/read logging, one task per scenario.
module tb_tile_line_fetcher;

  localparam int VADDR_W = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, line_start, line_done, busy;
  logic [7:0]         line_num, scroll_y;
  logic [8:0]         scroll_x;
  logic [VADDR_W-1:0] map_base;

  tile_line_fetcher_if #(.VADDR_W(VADDR_W)) bus ();

  tile_line_fetcher #(.NUM_TILES(41), .VADDR_W(VADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_num(line_num),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .map_base(map_base),
    .bus(bus), .line_done(line_done), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0]        mem [0:8191];
  int                 lat = 0;
  int                 cnt = 0;
  logic [VADDR_W-1:0] first_addr;
  int                 addr_unstable = 0;
  int                 ack_total = 0;
  int                 done_cnt = 0;
  logic [VADDR_W-1:0] rd_log [$];
  logic [8:0]         st_idx [$];
  logic [15:0]        st_data [$];
  int                 st_acks [$];

  // VRAM model: acks after lat cycles of a held request.
  always @(negedge clk) begin
    bus.vram_ack = 1'b0;
    if (bus.vram_req === 1'b1) begin
      if (cnt == 0) first_addr = bus.vram_addr;
      else if (bus.vram_addr !== first_addr) addr_unstable++;
      if (cnt >= lat) begin
        bus.vram_ack    = 1'b1;
        bus.vram_rddata = mem[bus.vram_addr];
        rd_log.push_back(bus.vram_addr);
        ack_total++;
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (bus.render_start === 1'b1) begin
      st_idx.push_back(bus.render_idx);
      st_data.push_back(bus.render_data);
      st_acks.push_back(ack_total);
    end
    if (line_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); st_idx.delete(); st_data.delete(); st_acks.delete();
    done_cnt = 0; addr_unstable = 0; ack_total = 0;
  endtask

  task automatic start_line(input logic [7:0] ln, input logic [8:0] sx,
                            input logic [7:0] sy, input logic [VADDR_W-1:0] mb);
    line_num = ln; scroll_x = sx; scroll_y = sy; map_base = mb;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (done_cnt != 0);
    tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if (bus.vram_req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_req_busy actual=%b%b required=00", bus.vram_req, busy);
    end
    checks++;
    if (bus.render_start !== 1'b0 || line_done !== 1'b0 || bus.render_idx !== 9'd0 || bus.render_data !== 16'd0) begin
      failures++; $display("FAIL reset_render actual=%b%b %0d %h required=00 0 0000",
                           bus.render_start, line_done, bus.render_idx, bus.render_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs(); lat = 0;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy actual=%b required=1", busy); end
    wait_done(3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout actual=no line_done required=line_done"); end
    checks++;
    if (rd_log.size() < 3 || rd_log[0] !== 13'd0 || rd_log[1] !== 13'd80 || rd_log[2] !== 13'd81) begin
      failures++; $display("FAIL basic_reads actual=%p required=0,80,81 first", rd_log);
    end
    checks++;
    if (st_idx.size() < 2 || st_idx[0] !== 9'd0 || st_data[0] !== 16'h1234 || st_idx[1] !== 9'd4 || st_data[1] !== 16'h5678) begin
      failures++; $display("FAIL basic_issue actual=%p %p required=0/1234 4/5678", st_idx, st_data);
    end
    checks++;
    if (st_idx.size() != 82 || done_cnt != 1 || rd_log.size() != 123) begin
      failures++; $display("FAIL basic_counts actual=starts %0d done %0d reads %0d required=82 1 123",
                           st_idx.size(), done_cnt, rd_log.size());
    end
    checks++;
    if (st_idx.size() < 82 || st_idx[80] !== 9'd320 || st_idx[81] !== 9'd324 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_last_tile actual=%0d %0d busy %b required=320 324 busy 0",
                           st_idx[80], st_idx[81], busy);
    end
  endtask

  task automatic test_scroll();
    bit ok;
    clear_logs();
    start_line(8'd0, 9'd3, 8'd0, 13'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || st_idx.size() < 3 || st_idx[0] !== 9'd509 || st_idx[1] !== 9'd1 || st_idx[2] !== 9'd5) begin
      failures++; $display("FAIL scroll_fine actual=%0d %0d %0d required=509 1 5", st_idx[0], st_idx[1], st_idx[2]);
    end
    clear_logs();
    start_line(8'd0, 9'h1F8, 8'd0, 13'h100);
    wait_done(3000, ok);
    checks++;
    if (!ok || rd_log.size() < 4 || rd_log[0] !== 13'h13F || rd_log[3] !== 13'h100) begin
      failures++; $display("FAIL scroll_col_wrap actual=%h %h required=13f 100", rd_log[0], rd_log[3]);
    end
    clear_logs();
    start_line(8'd10, 9'd0, 8'd250, 13'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || rd_log.size() < 3 || rd_log[0] !== 13'd0 || rd_log[1] !== 13'd88 || rd_log[2] !== 13'd89) begin
      failures++; $display("FAIL scroll_y_wrap actual=%0d %0d %0d required=0 88 89", rd_log[0], rd_log[1], rd_log[2]);
    end
  endtask

  task automatic test_flip();
    bit ok;
    clear_logs();
    mem[0] = 16'h0205;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || st_data.size() < 2 || st_data[0] !== 16'h8765 || st_data[1] !== 16'h4321 || st_idx[1] !== 9'd4) begin
      failures++; $display("FAIL hflip actual=%h %h required=8765 4321", st_data[0], st_data[1]);
    end
    clear_logs();
    mem[0] = 16'h0405;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || rd_log.size() < 3 || rd_log[1] !== 13'd94 || rd_log[2] !== 13'd95) begin
      failures++; $display("FAIL vflip actual=%0d %0d required=94 95", rd_log[1], rd_log[2]);
    end
    mem[0] = 16'h0005;
  endtask

  task automatic test_slow_vram();
    bit ok;
    clear_logs(); lat = 5;
    bus.render_busy = 1'b1; bus.render_last_pixel = 1'b0;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    repeat (40) tick();
    checks++;
    if (st_idx.size() != 0 || rd_log.size() != 3) begin
      failures++; $display("FAIL slow_stall actual=starts %0d reads %0d required=0 3", st_idx.size(), rd_log.size());
    end
    bus.render_last_pixel = 1'b1;
    tick();
    bus.render_last_pixel = 1'b0;
    checks++;
    if (st_idx.size() != 1 || st_data[0] !== 16'h1234 || st_acks[0] < 3) begin
      failures++; $display("FAIL slow_last_pixel actual=starts %0d data %h required=1 1234", st_idx.size(), st_data[0]);
    end
    repeat (5) tick();
    checks++;
    if (st_idx.size() != 1) begin
      failures++; $display("FAIL slow_hold_iss1 actual=%0d required=1", st_idx.size());
    end
    bus.render_busy = 1'b0;
    wait_done(5000, ok);
    checks++;
    if (!ok || addr_unstable != 0 || st_idx.size() != 82 || st_data[1] !== 16'h5678) begin
      failures++; $display("FAIL slow_complete actual=done %0b unstable %0d starts %0d required=1 0 82",
                           ok, addr_unstable, st_idx.size());
    end
  endtask

  task automatic test_abort_reset();
    clear_logs(); lat = 0;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    repeat (30) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (bus.vram_req !== 1'b0 || bus.render_start !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0) begin
      failures++; $display("FAIL abort_reset_outputs actual=%b%b%b%b required=0000",
                           bus.vram_req, bus.render_start, busy, line_done);
    end
    reset_n = 1'b1;
    tick();
    clear_logs();
    repeat (100) tick();
    checks++;
    if (rd_log.size() != 0 || st_idx.size() != 0 || done_cnt != 0) begin
      failures++; $display("FAIL abort_reset_quiet actual=reads %0d starts %0d done %0d required=0 0 0",
                           rd_log.size(), st_idx.size(), done_cnt);
    end
  endtask

  task automatic test_restart();
    bit ok;
    bit found = 1'b0;
    int n0, s0;
    logic [VADDR_W-1:0] inflight;
    clear_logs(); lat = 3;
    start_line(8'd0, 9'd0, 8'd0, 13'd0);
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      if (bus.vram_req === 1'b1 && bus.vram_ack === 1'b0 && rd_log.size() >= 4) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL restart_find actual=none required=in-flight read"); end
    n0 = rd_log.size(); s0 = st_idx.size(); inflight = bus.vram_addr;
    start_line(8'd8, 9'd0, 8'd0, 13'd0);
    wait_done(5000, ok);
    checks++;
    if (!ok || done_cnt != 1 || rd_log.size() < n0 + 2 || rd_log[n0] !== inflight || rd_log[n0+1] !== 13'd64) begin
      failures++; $display("FAIL restart_reads actual=%0d %0d done %0d required=%0d 64 done 1",
                           rd_log[n0], rd_log[n0+1], done_cnt, inflight);
    end
    checks++;
    if (st_idx.size() != s0 + 82 || st_idx[s0] !== 9'd0) begin
      failures++; $display("FAIL restart_issue actual=starts %0d idx %0d required=%0d 0",
                           st_idx.size(), st_idx[s0], s0 + 82);
    end
    lat = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0005; mem[80] = 16'h1234; mem[81] = 16'h5678;
    reset_n = 1'b0; line_start = 1'b0; line_num = 8'd0; scroll_x = 9'd0;
    scroll_y = 8'd0; map_base = 13'd0;
    bus.render_busy = 1'b0; bus.render_last_pixel = 1'b0; bus.vram_rddata = 16'h0000;
    test_reset();
    test_basic();
    test_scroll();
    test_flip();
    test_slow_vram();
    test_abort_reset();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
